// File: rtl/uart_rx_deframer_pkg.sv
// Shared UART frame configuration encodings and receive FSM types.
package uart_rx_deframer_pkg;

  localparam logic [1:0] PAR_NONE = 2'b00;
  localparam logic [1:0] PAR_EVEN = 2'b01;
  localparam logic [1:0] PAR_ODD  = 2'b10;

  localparam logic STOP_1 = 1'b0;
  localparam logic STOP_2 = 1'b1;
  localparam logic LEN_7  = 1'b0;
  localparam logic LEN_8  = 1'b1;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_START,
    ST_DATA,
    ST_PARITY,
    ST_STOP,
    ST_DONE,
    ST_BREAK
  } rx_state_e;

  typedef struct packed {
    logic [1:0] parity_type;
    logic       stop_bits;
    logic       data_length;
  } rx_cfg_t;

  // Encoding 2'b11 is treated like "none", so only even/odd carry a parity bit.
  function automatic logic parity_enabled(input logic [1:0] p);
    return (p == PAR_EVEN) || (p == PAR_ODD);
  endfunction

endpackage

// File: rtl/uart_rx_deframer_sync.sv
// Multi-flop synchronizer for the asynchronous rx line; resets to idle-high.
module uart_rx_deframer_sync #(
  parameter int unsigned SYNC_STAGES = 2
) (
  input  logic clk,
  input  logic rst,
  input  logic d,
  output logic q
);

  logic [SYNC_STAGES-1:0] ff_q;

  // Shift chain, preset to 1 so a reset never looks like a start bit.
  always_ff @(posedge clk) begin
    if (rst) ff_q <= '1;
    else     ff_q <= {ff_q[SYNC_STAGES-2:0], d};
  end

  assign q = ff_q[SYNC_STAGES-1];

endmodule

// File: rtl/uart_rx_deframer.sv
// UART receive deframer: 16x oversampled start/data/parity/stop recovery.
module uart_rx_deframer
  import uart_rx_deframer_pkg::*;
#(
  parameter int unsigned OVERSAMPLE  = 16,
  parameter int unsigned SYNC_STAGES = 2
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       sample_tick,
  input  logic       rx,
  input  logic [1:0] parity_type,
  input  logic       stop_bits,
  input  logic       data_length,
  output logic [7:0] data_out,
  output logic       data_valid,
  output logic       parity_error,
  output logic       framing_error,
  output logic       busy
);

  localparam int unsigned TW = $clog2(OVERSAMPLE);
  localparam logic [TW-1:0] TICK_MID  = TW'(OVERSAMPLE / 2 - 1);
  localparam logic [TW-1:0] TICK_LAST = TW'(OVERSAMPLE - 1);

  logic rx_s;

  rx_state_e     state_q, state_n;
  logic [TW-1:0] tick_q, tick_n;
  logic [2:0]    bit_q, bit_n;
  logic          stop_q, stop_n;
  logic [7:0]    shift_q, shift_n;
  logic          acc_q, acc_n;
  logic          perr_q, perr_n;
  logic          ferr_q, ferr_n;
  rx_cfg_t       cfg_q, cfg_n;

  logic [7:0] data_out_n;
  logic       data_valid_n;
  logic       parity_error_n;
  logic       framing_error_n;
  logic       busy_n;
  logic [2:0] last_bit;
  logic       stop_low;

  uart_rx_deframer_sync #(
    .SYNC_STAGES (SYNC_STAGES)
  ) u_sync (
    .clk (clk),
    .rst (rst),
    .d   (rx),
    .q   (rx_s)
  );

  assign last_bit = (cfg_q.data_length == LEN_8) ? 3'd7 : 3'd6;
  assign stop_low = ferr_q | ~rx_s;

  // State and datapath registers, including the registered outputs.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q       <= ST_IDLE;
      tick_q        <= '0;
      bit_q         <= '0;
      stop_q        <= 1'b0;
      shift_q       <= '0;
      acc_q         <= 1'b0;
      perr_q        <= 1'b0;
      ferr_q        <= 1'b0;
      cfg_q         <= '{parity_type: PAR_NONE, stop_bits: STOP_1, data_length: LEN_7};
      data_out      <= '0;
      data_valid    <= 1'b0;
      parity_error  <= 1'b0;
      framing_error <= 1'b0;
      busy          <= 1'b0;
    end else begin
      state_q       <= state_n;
      tick_q        <= tick_n;
      bit_q         <= bit_n;
      stop_q        <= stop_n;
      shift_q       <= shift_n;
      acc_q         <= acc_n;
      perr_q        <= perr_n;
      ferr_q        <= ferr_n;
      cfg_q         <= cfg_n;
      data_out      <= data_out_n;
      data_valid    <= data_valid_n;
      parity_error  <= parity_error_n;
      framing_error <= framing_error_n;
      busy          <= busy_n;
    end
  end

  // Next-state logic; everything except the DONE exit moves only on a tick.
  always_comb begin
    state_n         = state_q;
    tick_n          = tick_q;
    bit_n           = bit_q;
    stop_n          = stop_q;
    shift_n         = shift_q;
    acc_n           = acc_q;
    perr_n          = perr_q;
    ferr_n          = ferr_q;
    cfg_n           = cfg_q;
    data_out_n      = data_out;
    data_valid_n    = 1'b0;
    parity_error_n  = parity_error;
    framing_error_n = framing_error;

    case (state_q)
      ST_IDLE: begin
        if (sample_tick && !rx_s) begin
          state_n = ST_START;
          tick_n  = '0;
          cfg_n   = '{parity_type: parity_type, stop_bits: stop_bits, data_length: data_length};
        end
      end

      ST_START: begin
        if (sample_tick) begin
          if (tick_q == TICK_MID) begin
            tick_n = '0;
            if (rx_s) begin
              state_n = ST_IDLE;
            end else begin
              state_n = ST_DATA;
              bit_n   = '0;
              shift_n = '0;
              acc_n   = 1'b0;
              perr_n  = 1'b0;
              ferr_n  = 1'b0;
            end
          end else begin
            tick_n = tick_q + TW'(1);
          end
        end
      end

      ST_DATA: begin
        if (sample_tick) begin
          if (tick_q == TICK_LAST) begin
            tick_n  = '0;
            shift_n = {rx_s, shift_q[7:1]};
            acc_n   = acc_q ^ rx_s;
            bit_n   = bit_q + 3'd1;
            if (bit_q == last_bit) begin
              stop_n = 1'b0;
              if (parity_enabled(cfg_q.parity_type)) state_n = ST_PARITY;
              else                                   state_n = ST_STOP;
            end
          end else begin
            tick_n = tick_q + TW'(1);
          end
        end
      end

      ST_PARITY: begin
        if (sample_tick) begin
          if (tick_q == TICK_LAST) begin
            tick_n  = '0;
            perr_n  = (cfg_q.parity_type == PAR_ODD) ? ~(acc_q ^ rx_s) : (acc_q ^ rx_s);
            state_n = ST_STOP;
          end else begin
            tick_n = tick_q + TW'(1);
          end
        end
      end

      ST_STOP: begin
        if (sample_tick) begin
          if (tick_q == TICK_LAST) begin
            tick_n = '0;
            ferr_n = stop_low;
            if ((cfg_q.stop_bits == STOP_2) && !stop_q) begin
              stop_n = 1'b1;
            end else begin
              state_n         = ST_DONE;
              data_valid_n    = 1'b1;
              data_out_n      = (cfg_q.data_length == LEN_8) ? shift_q : {1'b0, shift_q[7:1]};
              parity_error_n  = perr_q;
              framing_error_n = stop_low;
            end
          end else begin
            tick_n = tick_q + TW'(1);
          end
        end
      end

      ST_DONE: begin
        state_n = framing_error ? ST_BREAK : ST_IDLE;
      end

      ST_BREAK: begin
        if (sample_tick && rx_s) state_n = ST_IDLE;
      end

      default: begin
        state_n = ST_IDLE;
      end
    endcase

    busy_n = (state_n != ST_IDLE);
  end

endmodule

// File: tb/tb_uart_rx_deframer.sv
// Directed bench for uart_rx_deframer: tick every 4 clk, 64 clk per bit.
module tb_uart_rx_deframer;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       sample_tick = 1'b0;
  logic       rx = 1'b1;
  logic [1:0] parity_type = 2'b00;
  logic       stop_bits = 1'b0;
  logic       data_length = 1'b0;
  logic [7:0] data_out;
  logic       data_valid;
  logic       parity_error;
  logic       framing_error;
  logic       busy;

  int checks = 0;
  int errors = 0;
  int vcount = 0;
  logic prev_v = 1'b0;
  logic [7:0] v_data [0:15];
  logic       v_pe   [0:15];
  logic       v_fe   [0:15];
  int base;

  uart_rx_deframer #(
    .OVERSAMPLE  (16),
    .SYNC_STAGES (2)
  ) dut (
    .clk           (clk),
    .rst           (rst),
    .sample_tick   (sample_tick),
    .rx            (rx),
    .parity_type   (parity_type),
    .stop_bits     (stop_bits),
    .data_length   (data_length),
    .data_out      (data_out),
    .data_valid    (data_valid),
    .parity_error  (parity_error),
    .framing_error (framing_error),
    .busy          (busy)
  );

  always #5 clk = ~clk;

  // One-clk tick every 4 clocks.
  initial begin
    forever begin
      repeat (3) @(posedge clk);
      #1 sample_tick = 1'b1;
      @(posedge clk);
      #1 sample_tick = 1'b0;
    end
  end

  // Record every data_valid pulse and check it never lasts two cycles.
  always @(negedge clk) begin
    if (data_valid) begin
      checks++;
      assert (prev_v === 1'b0) else begin
        errors++;
        $error("FAIL valid_width observed two-cycle pulse expected one-cycle");
      end
      v_data[vcount % 16] = data_out;
      v_pe[vcount % 16]   = parity_error;
      v_fe[vcount % 16]   = framing_error;
      vcount++;
    end
    prev_v = data_valid;
  end

  task automatic clks(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic send_bit(input logic b);
    rx = b;
    clks(64);
  endtask

  task automatic send_frame(input logic [7:0] d, input bit len8, input bit has_par,
                            input logic pbit, input int nstop, input logic stop_last);
    send_bit(1'b0);
    for (int i = 0; i < (len8 ? 8 : 7); i++) send_bit(d[i]);
    if (has_par) send_bit(pbit);
    for (int s = 0; s < nstop; s++) send_bit((s == nstop - 1) ? stop_last : 1'b1);
  endtask

  initial begin
    // Reset state
    clks(5);
    chk("rst_data_out", 32'(data_out), 32'h00);
    chk("rst_valid", 32'(data_valid), 32'h0);
    chk("rst_perr", 32'(parity_error), 32'h0);
    chk("rst_ferr", 32'(framing_error), 32'h0);
    chk("rst_busy", 32'(busy), 32'h0);
    rst = 1'b0;
    clks(20);

    // 7-bit, no parity, 1 stop: 0x55
    parity_type = 2'b00; stop_bits = 1'b0; data_length = 1'b0;
    base = vcount;
    send_frame(8'h55, 1'b0, 1'b0, 1'b0, 1, 1'b1);
    clks(8);
    chk("t1_count", 32'(vcount - base), 32'd1);
    chk("t1_data", 32'(v_data[base % 16]), 32'h55);
    chk("t1_perr", 32'(v_pe[base % 16]), 32'h0);
    chk("t1_ferr", 32'(v_fe[base % 16]), 32'h0);
    chk("t1_busy", 32'(busy), 32'h0);

    // 8-bit, even parity, 1 stop: 0xAA good then bad parity
    parity_type = 2'b01; stop_bits = 1'b0; data_length = 1'b1;
    base = vcount;
    send_frame(8'hAA, 1'b1, 1'b1, 1'b0, 1, 1'b1);
    clks(8);
    chk("t2a_count", 32'(vcount - base), 32'd1);
    chk("t2a_data", 32'(data_out), 32'hAA);
    chk("t2a_perr", 32'(parity_error), 32'h0);
    chk("t2a_ferr", 32'(framing_error), 32'h0);
    send_frame(8'hAA, 1'b1, 1'b1, 1'b1, 1, 1'b1);
    clks(8);
    chk("t2b_count", 32'(vcount - base), 32'd2);
    chk("t2b_data", 32'(data_out), 32'hAA);
    chk("t2b_perr", 32'(parity_error), 32'h1);

    // 8-bit, odd parity, 2 stop, second stop low: framing error then BREAK
    parity_type = 2'b10; stop_bits = 1'b1; data_length = 1'b1;
    base = vcount;
    send_frame(8'hF0, 1'b1, 1'b1, 1'b1, 2, 1'b0);
    chk("t3_count", 32'(vcount - base), 32'd1);
    chk("t3_data", 32'(data_out), 32'hF0);
    chk("t3_perr", 32'(parity_error), 32'h0);
    chk("t3_ferr", 32'(framing_error), 32'h1);
    clks(64);
    chk("t3_busy_break", 32'(busy), 32'h1);
    rx = 1'b1;
    clks(20);
    chk("t3_busy_idle", 32'(busy), 32'h0);
    chk("t3_no_retrigger", 32'(vcount - base), 32'd1);
    clks(64);

    // Glitch of 3 ticks, then a valid 0x3C frame
    parity_type = 2'b00; stop_bits = 1'b0; data_length = 1'b1;
    base = vcount;
    rx = 1'b0;
    clks(12);
    chk("t4_busy_start", 32'(busy), 32'h1);
    rx = 1'b1;
    clks(64);
    chk("t4_busy_abort", 32'(busy), 32'h0);
    chk("t4_no_valid", 32'(vcount - base), 32'd0);
    send_frame(8'h3C, 1'b1, 1'b0, 1'b0, 1, 1'b1);
    clks(8);
    chk("t4_count", 32'(vcount - base), 32'd1);
    chk("t4_data", 32'(data_out), 32'h3C);
    chk("t4_ferr", 32'(framing_error), 32'h0);

    // Reset during the 4th data bit of 0x81
    base = vcount;
    send_bit(1'b0);
    send_bit(1'b1);
    send_bit(1'b0);
    send_bit(1'b0);
    rx = 1'b0;
    clks(32);
    rst = 1'b1;
    clks(1);
    chk("t5_data_out", 32'(data_out), 32'h00);
    chk("t5_busy", 32'(busy), 32'h0);
    chk("t5_valid", 32'(data_valid), 32'h0);
    rst = 1'b0;
    rx = 1'b1;
    clks(128);
    chk("t5_no_valid", 32'(vcount - base), 32'd0);
    send_frame(8'h81, 1'b1, 1'b0, 1'b0, 1, 1'b1);
    clks(8);
    chk("t5_count", 32'(vcount - base), 32'd1);
    chk("t5_data", 32'(data_out), 32'h81);

    // Back-to-back 0x12 (no parity) and 0x34 (even parity), config change mid frame 1
    parity_type = 2'b00; stop_bits = 1'b1; data_length = 1'b1;
    base = vcount;
    fork
      send_frame(8'h12, 1'b1, 1'b0, 1'b0, 2, 1'b1);
      begin
        clks(200);
        parity_type = 2'b01;
      end
    join
    send_frame(8'h34, 1'b1, 1'b1, 1'b1, 2, 1'b1);
    clks(8);
    chk("t6_count", 32'(vcount - base), 32'd2);
    chk("t6_data0", 32'(v_data[base % 16]), 32'h12);
    chk("t6_perr0", 32'(v_pe[base % 16]), 32'h0);
    chk("t6_ferr0", 32'(v_fe[base % 16]), 32'h0);
    chk("t6_data1", 32'(v_data[(base + 1) % 16]), 32'h34);
    chk("t6_perr1", 32'(v_pe[(base + 1) % 16]), 32'h0);
    chk("t6_ferr1", 32'(v_fe[(base + 1) % 16]), 32'h0);
    chk("t6_busy", 32'(busy), 32'h0);

    clks(10);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
